sort_mem_responder: RTL and testbench

Memory-side responder for the insertion-sort engine's AXI-lite-style read/write channels. Holds the array in a `DEPTH`-word register file and answers AR/R and AW/W/B handshakes issued by the sort controller. Provides a backdoor load port and a debug read port so a bench or host can preload the unsorted array and inspect the result.

---
 rtl/sort_pkg.sv | 18 +
 rtl/sort_mem_array.sv | 40 ++++
 rtl/sort_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_sort_mem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Types and response encodings shared by the sort controller and its memory responder.
package sort_pkg;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_COLLECT,
        WR_COMMIT,
        WR_RESP
    } wr_state_t;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/sort_mem_array.sv
// DEPTH-word register file with one synchronous write port and two combinational
// read ports; out-of-range reads return 0 and out-of-range writes are dropped.
module sort_mem_array #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int DEPTH     = 10
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_WDTH-1:0] waddr_i,
    input  logic [DATA_WDTH-1:0] wdata_i,
    input  logic [ADDR_WDTH-1:0] raddr_a_i,
    output logic [DATA_WDTH-1:0] rdata_a_o,
    input  logic [ADDR_WDTH-1:0] raddr_b_i,
    output logic [DATA_WDTH-1:0] rdata_b_o
);

    localparam logic [ADDR_WDTH:0] DEPTH_L = (ADDR_WDTH + 1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_WDTH-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    logic [DATA_WDTH-1:0] mem_q [DEPTH];

    // No reset: contents survive a controller reset by design.
    always_ff @(posedge clk) begin
        if (we_i && in_range(waddr_i)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (in_range(raddr_a_i)) rdata_a_o = mem_q[raddr_a_i];
        if (in_range(raddr_b_i)) rdata_b_o = mem_q[raddr_b_i];
    end

endmodule

// File: rtl/sort_mem_responder.sv
// Memory-side AXI-lite-style responder for the sort engine: AR/R read FSM,
// AW/W/B write FSM, backdoor load with priority over commits, and a debug read port.
module sort_mem_responder
    import sort_pkg::*;
#(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1,
    parameter int DEPTH     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ar_valid,
    output logic                 ar_ready,
    input  logic [ADDR_WDTH-1:0] ar_addr,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic [DATA_WDTH-1:0] r_data,
    output logic [RESP_WDTH-1:0] r_resp,
    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [ADDR_WDTH-1:0] aw_addr,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DATA_WDTH-1:0] w_data,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic [RESP_WDTH-1:0] b_resp,
    input  logic                 ld_en,
    input  logic [ADDR_WDTH-1:0] ld_addr,
    input  logic [DATA_WDTH-1:0] ld_data,
    input  logic [ADDR_WDTH-1:0] dbg_addr,
    output logic [DATA_WDTH-1:0] dbg_data
);

    localparam logic [ADDR_WDTH:0] DEPTH_L = (ADDR_WDTH + 1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_WDTH-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    rd_state_t            rd_state_q, rd_state_d;
    logic                 ar_ready_q, ar_ready_d;
    logic                 r_valid_q,  r_valid_d;
    logic [DATA_WDTH-1:0] r_data_q,   r_data_d;
    logic [RESP_WDTH-1:0] r_resp_q,   r_resp_d;

    wr_state_t            wr_state_q, wr_state_d;
    logic                 aw_have_q,  aw_have_d;
    logic                 w_have_q,   w_have_d;
    logic [ADDR_WDTH-1:0] aw_addr_q,  aw_addr_d;
    logic [DATA_WDTH-1:0] w_data_q,   w_data_d;
    logic                 aw_ready_q, aw_ready_d;
    logic                 w_ready_q,  w_ready_d;
    logic                 b_valid_q,  b_valid_d;
    logic [RESP_WDTH-1:0] b_resp_q,   b_resp_d;

    logic                 ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic                 commit;
    logic                 mem_we;
    logic [ADDR_WDTH-1:0] mem_waddr;
    logic [DATA_WDTH-1:0] mem_wdata;
    logic [DATA_WDTH-1:0] mem_rdata;

    assign ar_hs = ar_valid && ar_ready_q;
    assign r_hs  = r_valid_q && r_ready;
    assign aw_hs = aw_valid && aw_ready_q;
    assign w_hs  = w_valid && w_ready_q;
    assign b_hs  = b_valid_q && b_ready;

    // A load owns the single write port; a pending commit waits one cycle behind it.
    assign commit    = (wr_state_q == WR_COMMIT) && !ld_en;
    assign mem_we    = ld_en || (commit && in_range(aw_addr_q));
    assign mem_waddr = ld_en ? ld_addr : aw_addr_q;
    assign mem_wdata = ld_en ? ld_data : w_data_q;

    sort_mem_array #(
        .ADDR_WDTH (ADDR_WDTH),
        .DATA_WDTH (DATA_WDTH),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk       (clk),
        .we_i      (mem_we),
        .waddr_i   (mem_waddr),
        .wdata_i   (mem_wdata),
        .raddr_a_i (ar_addr),
        .rdata_a_o (mem_rdata),
        .raddr_b_i (dbg_addr),
        .rdata_b_o (dbg_data)
    );

    // Read FSM. The array read is pre-edge, so a same-cycle commit is not visible.
    always_comb begin
        rd_state_d = rd_state_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_RESP;
                    r_data_d   = mem_rdata;
                    r_resp_d   = in_range(ar_addr) ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_ERR);
                end
            end
            RD_RESP: begin
                if (r_hs) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
        ar_ready_d = (rd_state_d == RD_IDLE);
        r_valid_d  = (rd_state_d == RD_RESP);
    end

    // Write FSM
    always_comb begin
        wr_state_d = wr_state_q;
        aw_have_d  = aw_have_q;
        w_have_d   = w_have_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        b_resp_d   = b_resp_q;
        case (wr_state_q)
            WR_COLLECT: begin
                if (aw_hs) begin
                    aw_have_d = 1'b1;
                    aw_addr_d = aw_addr;
                end
                if (w_hs) begin
                    w_have_d = 1'b1;
                    w_data_d = w_data;
                end
                if (aw_have_d && w_have_d) wr_state_d = WR_COMMIT;
            end
            WR_COMMIT: begin
                if (commit) begin
                    wr_state_d = WR_RESP;
                    b_resp_d   = in_range(aw_addr_q) ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_ERR);
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    aw_have_d  = 1'b0;
                    w_have_d   = 1'b0;
                    wr_state_d = WR_COLLECT;
                end
            end
            default: wr_state_d = WR_COLLECT;
        endcase
        aw_ready_d = (wr_state_d == WR_COLLECT) && !aw_have_d;
        w_ready_d  = (wr_state_d == WR_COLLECT) && !w_have_d;
        b_valid_d  = (wr_state_d == WR_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
            wr_state_q <= WR_COLLECT;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            wr_state_q <= wr_state_d;
            aw_have_q  <= aw_have_d;
            w_have_q   <= w_have_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
        end
    end

    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;
    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign b_valid  = b_valid_q;
    assign b_resp   = b_resp_q;

endmodule

// File: tb/tb_sort_mem_responder.sv
// Directed bench for sort_mem_responder: table-driven debug and read vectors
// plus hand-written sequences for write ordering, collisions and reset.
module tb_sort_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid, ar_ready;
    logic [3:0]  ar_addr;
    logic        r_valid, r_ready;
    logic [31:0] r_data;
    logic [0:0]  r_resp;
    logic        aw_valid, aw_ready;
    logic [3:0]  aw_addr;
    logic        w_valid, w_ready;
    logic [31:0] w_data;
    logic        b_valid, b_ready;
    logic [0:0]  b_resp;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    sort_mem_responder #(
        .ADDR_WDTH (4),
        .DATA_WDTH (32),
        .RESP_WDTH (1),
        .DEPTH     (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ar_valid (ar_valid),
        .ar_ready (ar_ready),
        .ar_addr  (ar_addr),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_data   (r_data),
        .r_resp   (r_resp),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .aw_addr  (aw_addr),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_data   (w_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_resp   (b_resp),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp_data;
        logic        exp_resp;
    } vec_t;

    vec_t dbg_tbl[7];
    vec_t rd_tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_dbg(input string name, input logic [3:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    task automatic do_read(input string name, input logic [3:0] a,
                           input logic [31:0] exp_d, input logic exp_r);
        chk({name, " ar_ready"}, 32'(ar_ready), 32'd1);
        ar_valid = 1'b1;
        ar_addr  = a;
        tick();
        ar_valid = 1'b0;
        chk({name, " r_valid"}, 32'(r_valid), 32'd1);
        chk({name, " r_data"}, r_data, exp_d);
        chk({name, " r_resp"}, 32'(r_resp), 32'(exp_r));
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    // Simultaneous AW+W; commit one edge later, then B handshake.
    task automatic do_write(input string name, input logic [3:0] a,
                            input logic [31:0] d, input logic exp_r);
        aw_valid = 1'b1;
        aw_addr  = a;
        w_valid  = 1'b1;
        w_data   = d;
        tick();
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        chk({name, " b_valid early"}, 32'(b_valid), 32'd0);
        tick();
        chk({name, " b_valid"}, 32'(b_valid), 32'd1);
        chk({name, " b_resp"}, 32'(b_resp), 32'(exp_r));
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
    endtask

    initial begin
        dbg_tbl[0] = '{4'd0,  32'd5,    1'b0};
        dbg_tbl[1] = '{4'd1,  32'd3,    1'b0};
        dbg_tbl[2] = '{4'd2,  32'd8,    1'b0};
        dbg_tbl[3] = '{4'd3,  32'd1,    1'b0};
        dbg_tbl[4] = '{4'd9,  32'h99,   1'b0};
        dbg_tbl[5] = '{4'd10, 32'd0,    1'b0};
        dbg_tbl[6] = '{4'd15, 32'd0,    1'b0};

        rd_tbl[0] = '{4'd0,  32'd5,  1'b0};
        rd_tbl[1] = '{4'd3,  32'd1,  1'b0};
        rd_tbl[2] = '{4'd9,  32'h99, 1'b0};
        rd_tbl[3] = '{4'd10, 32'd0,  1'b1};
        rd_tbl[4] = '{4'd15, 32'd0,  1'b1};

        rst = 1'b1;
        ar_valid = 1'b0; ar_addr = '0; r_ready = 1'b0;
        aw_valid = 1'b0; aw_addr = '0; w_valid = 1'b0; w_data = '0; b_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;

        // Reset held three cycles; all outputs low throughout
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst outputs", {ar_ready, aw_ready, w_ready, r_valid, b_valid, r_resp, b_resp}, 32'd0);
            chk("rst r_data", r_data, 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("readies after rst", {ar_ready, aw_ready, w_ready}, 32'b111);

        // Preload, including one out-of-range load that must be ignored
        ld_en = 1'b1;
        ld_addr = 4'd0;  ld_data = 32'd5;    tick();
        ld_addr = 4'd1;  ld_data = 32'd3;    tick();
        ld_addr = 4'd2;  ld_data = 32'd8;    tick();
        ld_addr = 4'd3;  ld_data = 32'd1;    tick();
        ld_addr = 4'd9;  ld_data = 32'h99;   tick();
        ld_addr = 4'd10; ld_data = 32'h77;   tick();
        ld_en = 1'b0;

        for (int i = 0; i < 7; i++) begin
            chk_dbg($sformatf("dbg[%0d]", dbg_tbl[i].addr), dbg_tbl[i].addr, dbg_tbl[i].exp_data);
        end
        for (int i = 0; i < 5; i++) begin
            do_read($sformatf("rd[%0d]", rd_tbl[i].addr), rd_tbl[i].addr,
                    rd_tbl[i].exp_data, rd_tbl[i].exp_resp);
        end

        // Single read with r_ready held low for 4 cycles
        ar_valid = 1'b1; ar_addr = 4'd2;
        tick();
        ar_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold r_valid", 32'(r_valid), 32'd1);
            chk("hold r_data", r_data, 32'd8);
            chk("hold ar_ready", 32'(ar_ready), 32'd0);
            if (i < 3) tick();
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk("after R r_valid", 32'(r_valid), 32'd0);
        chk("after R ar_ready", 32'(ar_ready), 32'd1);

        // W before AW
        w_valid = 1'b1; w_data = 32'd7;
        tick();
        w_valid = 1'b0;
        chk("w captured w_ready", 32'(w_ready), 32'd0);
        chk("w captured aw_ready", 32'(aw_ready), 32'd1);
        tick();
        tick();
        chk("waiting b_valid", 32'(b_valid), 32'd0);
        aw_valid = 1'b1; aw_addr = 4'd1;
        tick();
        aw_valid = 1'b0;
        chk("commit b_valid", 32'(b_valid), 32'd0);
        tick();
        chk("wfirst b_valid", 32'(b_valid), 32'd1);
        chk("wfirst b_resp", 32'(b_resp), 32'd0);
        chk_dbg("wfirst dbg[1]", 4'd1, 32'd7);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        chk("after B", {b_valid, aw_ready, w_ready}, 32'b011);

        // Out of range
        do_read("oor rd", 4'd12, 32'd0, 1'b1);
        do_write("oor wr", 4'd12, 32'd9, 1'b1);
        chk_dbg("oor dbg[0]", 4'd0, 32'd5);
        chk_dbg("oor dbg[1]", 4'd1, 32'd7);
        chk_dbg("oor dbg[2]", 4'd2, 32'd8);
        chk_dbg("oor dbg[3]", 4'd3, 32'd1);

        // Load collides with commit: load first, AXI write lands after
        aw_valid = 1'b1; aw_addr = 4'd0; w_valid = 1'b1; w_data = 32'd6;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 4'd0; ld_data = 32'd4;
        tick();
        ld_en = 1'b0;
        chk("ldcol b_valid delayed", 32'(b_valid), 32'd0);
        chk_dbg("ldcol dbg after load", 4'd0, 32'd4);
        tick();
        chk("ldcol b_valid", 32'(b_valid), 32'd1);
        chk("ldcol b_resp", 32'(b_resp), 32'd0);
        chk_dbg("ldcol final", 4'd0, 32'd6);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;

        // AR handshake on the commit edge to the same address returns old data
        aw_valid = 1'b1; aw_addr = 4'd0; w_valid = 1'b1; w_data = 32'd11;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        ar_valid = 1'b1; ar_addr = 4'd0;
        tick();
        ar_valid = 1'b0;
        chk("rwcol r_valid", 32'(r_valid), 32'd1);
        chk("rwcol r_data old", r_data, 32'd6);
        chk("rwcol b_valid", 32'(b_valid), 32'd1);
        chk_dbg("rwcol dbg new", 4'd0, 32'd11);
        r_ready = 1'b1; b_ready = 1'b1;
        tick();
        r_ready = 1'b0; b_ready = 1'b0;

        // Reset while a B response is pending
        aw_valid = 1'b1; aw_addr = 4'd3; w_valid = 1'b1; w_data = 32'd21;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        tick();
        tick();
        chk("pre-rst b_valid", 32'(b_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid-rst b_valid", 32'(b_valid), 32'd0);
        chk("mid-rst readies", {ar_ready, aw_ready, w_ready}, 32'd0);
        chk_dbg("mid-rst persists", 4'd3, 32'd21);
        rst = 1'b0;
        tick();
        chk("post-rst readies", {ar_ready, aw_ready, w_ready, b_valid}, 32'b1110);
        do_read("post-rst rd", 4'd3, 32'd21, 1'b0);
        do_write("post-rst wr", 4'd4, 32'd55, 1'b0);
        chk_dbg("post-rst dbg[4]", 4'd4, 32'd55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
